// File: rtl/usb_ctrl_pkg.sv
// Shared constants and helpers for the USB game-controller front end.
// Used by button_conditioner and usb_controller alike.
package usb_ctrl_pkg;

    localparam int NUM_BTN                 = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_A = 4;
    localparam int BTN_B = 5;
    localparam int BTN_X = 6;
    localparam int BTN_Y = 7;

    typedef enum logic {
        MODE_PARALLEL = 1'b0,
        MODE_SERIAL   = 1'b1
    } mode_e;

    // A pad reporting both opposing directions is treated as neither pressed.
    function automatic logic [NUM_BTN-1:0] mask_opposing(input logic [NUM_BTN-1:0] btn);
        logic [NUM_BTN-1:0] masked;
        masked = btn;
        if (btn[BTN_L] && btn[BTN_R]) begin
            masked[BTN_L] = 1'b0;
            masked[BTN_R] = 1'b0;
        end
        if (btn[BTN_U] && btn[BTN_D]) begin
            masked[BTN_U] = 1'b0;
            masked[BTN_D] = 1'b0;
        end
        return masked;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchronizer, stability counter and stable register.
// stable_next exposes the value the stable register takes on the coming edge.
module debounce_cell
    import usb_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // Any sample matching the stable value restarts the count, so short glitches never land.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (sync_out != stable) begin
            if (cnt == CNT_LAST) begin
                stable_next = sync_out;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the eight pad buttons and the mode switch, masks opposing directions,
// generates press pulses and holds mode changes until no button is active.
module button_conditioner
    import usb_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               mode_raw,
    output logic               L,
    output logic               R,
    output logic               U,
    output logic               D,
    output logic               A,
    output logic               B,
    output logic               X,
    output logic               Y,
    output logic               mode,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic               active
);

    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_stable_next;
    logic [NUM_BTN-1:0] btn_masked;
    logic [NUM_BTN-1:0] btn_masked_next;
    logic               mode_stable;
    logic               mode_next_unused;
    mode_e              mode_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .raw        (btn_raw[i]),
            .stable     (btn_stable[i]),
            .stable_next(btn_stable_next[i])
        );
    end

    debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode_cell (
        .clk        (clk),
        .reset      (reset),
        .raw        (mode_raw),
        .stable     (mode_stable),
        .stable_next(mode_next_unused)
    );

    assign btn_masked      = mask_opposing(btn_stable);
    assign btn_masked_next = mask_opposing(btn_stable_next);

    assign L      = btn_masked[BTN_L];
    assign R      = btn_masked[BTN_R];
    assign U      = btn_masked[BTN_U];
    assign D      = btn_masked[BTN_D];
    assign A      = btn_masked[BTN_A];
    assign B      = btn_masked[BTN_B];
    assign X      = btn_masked[BTN_X];
    assign Y      = btn_masked[BTN_Y];
    assign active = |btn_masked;
    assign mode   = mode_q;

    // Looking one edge ahead lets the pulse coincide with the rising masked output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_pulse <= '0;
        end else begin
            press_pulse <= btn_masked_next & ~btn_masked;
        end
    end

    // A debounced mode change stays pending while any button is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_PARALLEL;
        end else if (!active) begin
            mode_q <= mode_e'(mode_stable);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] btn_raw;
    logic       mode_raw;
    logic       L, R, U, D, A, B, X, Y;
    logic       mode;
    logic [7:0] press_pulse;
    logic       active;

    int vectors     = 0;
    int miscompares = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .mode_raw   (mode_raw),
        .L          (L),
        .R          (R),
        .U          (U),
        .D          (D),
        .A          (A),
        .B          (B),
        .X          (X),
        .Y          (Y),
        .mode       (mode),
        .press_pulse(press_pulse),
        .active     (active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] btns();
        return {Y, X, B, A, D, U, R, L};
    endfunction

    task automatic applyStimulus(input logic [7:0] btn, input logic m);
        btn_raw  = btn;
        mode_raw = m;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(8'hFF, 1'b1);
        #1;
        checkOutput("rst_btns_immediate", btns(), 8'h00);
        tick(3);
        checkOutput("rst_btns", btns(), 8'h00);
        checkOutput("rst_pulse", press_pulse, 8'h00);
        checkOutput("rst_active", {7'd0, active}, 8'h00);
        checkOutput("rst_mode", {7'd0, mode}, 8'h00);
        applyStimulus(8'h00, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(8);
        checkOutput("idle_btns", btns(), 8'h00);

        // Clean press of L: visible after exactly 6 edges
        applyStimulus(8'h01, 1'b0);
        tick(5);
        checkOutput("press_edge5_btns", btns(), 8'h00);
        checkOutput("press_edge5_pulse", press_pulse, 8'h00);
        tick(1);
        checkOutput("press_edge6_btns", btns(), 8'h01);
        checkOutput("press_edge6_pulse", press_pulse, 8'h01);
        checkOutput("press_edge6_active", {7'd0, active}, 8'h01);
        tick(1);
        checkOutput("press_edge7_pulse", press_pulse, 8'h00);
        checkOutput("press_edge7_btns", btns(), 8'h01);
        tick(3);
        applyStimulus(8'h00, 1'b0);
        tick(5);
        checkOutput("release_edge5_btns", btns(), 8'h01);
        tick(1);
        checkOutput("release_edge6_btns", btns(), 8'h00);
        checkOutput("release_no_pulse", press_pulse, 8'h00);
        checkOutput("release_active", {7'd0, active}, 8'h00);
        tick(4);

        // Glitch on A lasting 3 cycles must be ignored
        applyStimulus(8'h10, 1'b0);
        tick(3);
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("glitch_btns", btns(), 8'h00);
            checkOutput("glitch_pulse", press_pulse, 8'h00);
        end

        // U and D together cancel; releasing D unmasks U with a pulse
        applyStimulus(8'h0C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("conflict_btns", btns(), 8'h00);
            checkOutput("conflict_pulse", press_pulse, 8'h00);
        end
        checkOutput("conflict_active", {7'd0, active}, 8'h00);
        applyStimulus(8'h04, 1'b0);
        tick(5);
        checkOutput("unmask_edge5_btns", btns(), 8'h00);
        tick(1);
        checkOutput("unmask_edge6_btns", btns(), 8'h04);
        checkOutput("unmask_edge6_pulse", press_pulse, 8'h04);
        tick(1);
        checkOutput("unmask_edge7_pulse", press_pulse, 8'h00);
        applyStimulus(8'h00, 1'b0);
        tick(10);

        // Mode change held while X is pressed
        applyStimulus(8'h40, 1'b0);
        tick(8);
        checkOutput("hold_x_btns", btns(), 8'h40);
        applyStimulus(8'h40, 1'b1);
        tick(10);
        checkOutput("hold_mode_pending", {7'd0, mode}, 8'h00);
        applyStimulus(8'h00, 1'b1);
        tick(6);
        checkOutput("hold_x_fall_btns", btns(), 8'h00);
        checkOutput("hold_x_fall_mode", {7'd0, mode}, 8'h00);
        tick(1);
        checkOutput("hold_mode_applied", {7'd0, mode}, 8'h01);

        // Reset asserted mid-count on R
        applyStimulus(8'h02, 1'b1);
        tick(3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_btns", btns(), 8'h00);
        checkOutput("midrst_mode", {7'd0, mode}, 8'h00);
        checkOutput("midrst_pulse", press_pulse, 8'h00);
        checkOutput("midrst_active", {7'd0, active}, 8'h00);
        tick(2);
        reset = 1'b1;
        tick(1);
        checkOutput("post_rst_edge1_pulse", press_pulse, 8'h00);
        tick(4);
        checkOutput("post_rst_edge5_btns", btns(), 8'h00);
        tick(1);
        checkOutput("post_rst_edge6_btns", btns(), 8'h02);
        checkOutput("post_rst_edge6_pulse", press_pulse, 8'h02);
        tick(1);
        checkOutput("post_rst_mode_held", {7'd0, mode}, 8'h00);
        applyStimulus(8'h00, 1'b0);
        tick(12);

        // Simultaneous presses; L and R cancel, then releasing R unmasks L
        applyStimulus(8'h33, 1'b0);
        tick(6);
        checkOutput("multi_btns", btns(), 8'h30);
        checkOutput("multi_pulse", press_pulse, 8'h30);
        checkOutput("multi_active", {7'd0, active}, 8'h01);
        applyStimulus(8'h31, 1'b0);
        tick(6);
        checkOutput("lr_unmask_btns", btns(), 8'h31);
        checkOutput("lr_unmask_pulse", press_pulse, 8'h01);
        tick(1);
        checkOutput("lr_unmask_pulse_clear", press_pulse, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port btn_raw, input, 8 bits: raw pad levels, bit order [0]=L [1]=R [2]=U [3]=D [4]=A [5]=B [6]=X [7]=Y, 1=pressed.
REQ-005 SHALL have port mode_raw, input, 1 bit: raw mode switch, 0=parallel/gaming, 1=serial/navigation.
REQ-006 SHALL have ports L, R, U, D, A, B, X, Y, output, 1 bit each: conditioned levels feeding usb_controller.
REQ-007 SHALL have port mode, output, 1 bit: conditioned mode feeding usb_controller.
REQ-008 SHALL have port press_pulse, output, 8 bits: one-cycle pulse per button on its conditioned 0->1 transition, same bit order as btn_raw.
REQ-009 SHALL have port active, output, 1 bit: OR of the eight conditioned button outputs.

Function
REQ-010 SHALL pass each of the 9 raw inputs through its own 2-flop synchronizer before any other logic.
REQ-011 SHALL keep, per input, a stable register and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 SHALL clear the counter on every edge where synchronized sample equals the stable value.
REQ-013 SHALL increment the counter on every edge where the sample differs from the stable value.
REQ-014 SHALL load the sample into the stable register and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 and the sample still differs.
REQ-015 SHALL give a raw-to-stable latency of exactly DEBOUNCE_CYCLES+2 rising edges for a clean level change.
REQ-016 SHALL ignore any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles; the stable value does not change and the counter returns to 0.
REQ-017 SHALL mask opposing directions: stable L and R both 1 drives L=R=0; stable U and D both 1 drives U=D=0; A, B, X and Y are never masked.
REQ-018 SHALL drive outputs L..Y combinationally from the masked stable registers, with no extra register stage.
REQ-019 SHALL register press_pulse[i] high for exactly one cycle when masked output i goes 0->1 (including unmasking when the opposing button is released); it SHALL NOT pulse on 1->0.
REQ-020 SHALL update the mode output from the debounced mode only while active=0; a debounced mode change while active=1 is held pending and applied on the first cycle active=0.
REQ-021 SHALL allow simultaneous transitions on different inputs to be accepted independently on the same edge.

Reset
REQ-022 SHALL, while reset=0, asynchronously force all synchronizer flops, stable registers, counters, pending-mode state and press_pulse to 0, giving outputs L..Y=0, mode=0, press_pulse=0, active=0.
REQ-023 SHALL discard an in-progress debounce count when reset asserts mid-count, with no output change after release until a full DEBOUNCE_CYCLES+2 latency has elapsed.
REQ-024 SHALL NOT pulse press_pulse on the first cycle after reset release if raw inputs are already high; the first pulse comes after the full latency.

Structure
REQ-025 SHALL take the button index constants (BTN_L=0..BTN_Y=7), NUM_BTN=8 and the DEBOUNCE_CYCLES default from shared package usb_ctrl_pkg, which usb_controller also uses.
REQ-026 SHALL implement synchronizer plus counter plus stable register as a single sub-module debounce_cell, instantiated 9 times; masking, pulse and mode-hold logic stay in button_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover clean press: btn_raw=8'h01 held 10 cycles -> L=1 after exactly 6 edges, press_pulse=8'h01 for 1 cycle, active=1.
REQ-028 SHALL cover glitch: btn_raw[4] high for 3 cycles then low -> A stays 0, press_pulse stays 0.
REQ-029 SHALL cover conflict: U and D raised together -> U=D=0, active=0, no pulse; D then released -> U=1 after latency, press_pulse[2]=1 once.
REQ-030 SHALL cover mode hold: X held, mode_raw 0->1 -> mode stays 0; X released -> mode=1 on the cycle after X falls.
REQ-031 SHALL cover reset mid-count: btn_raw[1]=1 for 3 cycles, reset pulsed low asynchronously between edges -> all outputs 0 immediately; R=1 exactly 6 edges after release.
